// File: rtl/cache_mem_arbiter.sv
// Two-client arbiter sharing the pmem cache-line port between the I-cache and D-cache miss paths.
// Define ARB_ROUND_ROBIN_EN for round-robin priority; otherwise the D-side has fixed priority.
module cache_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              arb_timeout
);

  localparam int               CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(TIMEOUT);
  localparam bit               WD_EN  = (TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  state_t            state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic              timeout_q, timeout_d;
  logic              d_req, pick_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic              rr_i_first_q, rr_i_first_d;
`endif

  assign d_req = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
  assign pick_d = d_req & ~(i_read & rr_i_first_q);
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wd_cnt_d    = wd_cnt_q;
    timeout_d   = timeout_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_i_first_d = rr_i_first_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          // A simultaneous read+write from the D-side is a writeback.
          state_d     = GRANT_D;
          mem_write_d = d_write;
          mem_read_d  = ~d_write;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          wd_cnt_d    = '0;
        end else if (i_read) begin
          state_d     = GRANT_I;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = i_addr;
          wd_cnt_d    = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_resp) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          rr_i_first_d = (state_q == GRANT_D);
`endif
        end else if (WD_EN && (wd_cnt_q != WD_MAX)) begin
          // Saturating count; the flag is sticky and the FSM keeps waiting.
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
          if (wd_cnt_d == WD_MAX) timeout_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_i_first_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_i_first_q <= rr_i_first_d;
`endif
    end
  end

  // Responses are combinational so the client sees completion in the mem_resp cycle.
  assign i_resp      = (state_q == GRANT_I) & mem_resp;
  assign d_resp      = (state_q == GRANT_D) & mem_resp;
  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign arb_timeout = timeout_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus a randomized run
// against a transaction-timeline reference model.
module tb_cache_mem_arbiter;
  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 256;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;
  logic              arb_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .arb_timeout(arb_timeout)
  );

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Move to just after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling, still well before the falling edge.
  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    mem_resp = 1'b1;
    #3;
    total++; if (mem_read !== 1'b0 || mem_write !== 1'b0)
      $display("FAIL reset_strobes: got rd=%b wr=%b want 0 0", mem_read, mem_write);
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    total++; if (mem_wdata !== '0) begin bad++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    total++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      bad++; $display("FAIL reset_resp: got i=%b d=%b want 0 0", i_resp, d_resp);
    end
    total++; if (arb_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", arb_timeout); end
    if (mem_read !== 1'b0 || mem_write !== 1'b0) bad++;
    @(posedge clk);
    #1 rst = 1'b1;
    mem_resp = 1'b0;
  endtask

  task automatic test_lone_read();
    logic [LINE_W-1:0] a5;
    a5 = {(LINE_W/8){8'hA5}};
    step();
    i_read = 1'b1; i_addr = 32'h0000_1040;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      step();
      if (cyc == 5) begin mem_resp = 1'b1; mem_rdata = a5; end
      settle();
      total++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
        bad++; $display("FAIL lone_strobe c%0d: got rd=%b wr=%b want 1 0", cyc, mem_read, mem_write);
      end
      total++; if (mem_addr !== 32'h0000_1040) begin
        bad++; $display("FAIL lone_addr c%0d: got %h want 00001040", cyc, mem_addr);
      end
      total++; if (i_resp !== (cyc == 5) || d_resp !== 1'b0) begin
        bad++; $display("FAIL lone_resp c%0d: got i=%b d=%b want %b 0", cyc, i_resp, d_resp, cyc == 5);
      end
    end
    total++; if (i_rdata !== a5) begin bad++; $display("FAIL lone_rdata: got %h want %h", i_rdata, a5); end
    // Cycle 6 is the turnaround cycle; a stray mem_resp there must be ignored.
    step();
    i_read = 1'b0; mem_resp = 1'b1; mem_rdata = rand_line();
    settle();
    total++; if (mem_read !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
      bad++; $display("FAIL lone_done: got rd=%b i=%b d=%b want 0 0 0", mem_read, i_resp, d_resp);
    end
    for (int cyc = 7; cyc <= 8; cyc++) begin
      step();
      mem_resp = 1'b0;
      settle();
      total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
        bad++; $display("FAIL lone_after c%0d: got rd=%b wr=%b want 0 0", cyc, mem_read, mem_write);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [LINE_W-1:0] wd;
    wd = {(LINE_W/32){32'h1234_5678}};
    step();
    i_read = 1'b1; i_addr = 32'h0000_1080;
    d_write = 1'b1; d_addr = 32'h0000_2000; d_wdata = wd;
    step(); settle();
    total++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin
      bad++; $display("FAIL sim_d_strobe: got rd=%b wr=%b want 0 1", mem_read, mem_write);
    end
    total++; if (mem_addr !== 32'h0000_2000 || mem_wdata !== wd) begin
      bad++; $display("FAIL sim_d_req: got addr=%h wdata=%h want 00002000 %h", mem_addr, mem_wdata, wd);
    end
    step(); mem_resp = 1'b1; settle();
    total++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      bad++; $display("FAIL sim_d_resp: got i=%b d=%b want 0 1", i_resp, d_resp);
    end
    for (int cyc = 3; cyc <= 4; cyc++) begin
      step();
      mem_resp = 1'b0; d_write = 1'b0;
      settle();
      total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
        bad++; $display("FAIL sim_gap c%0d: got rd=%b wr=%b want 0 0", cyc, mem_read, mem_write);
      end
    end
    step(); settle();
    total++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h0000_1080) begin
      bad++; $display("FAIL sim_i_grant: got rd=%b wr=%b addr=%h want 1 0 00001080", mem_read, mem_write, mem_addr);
    end
    step(); mem_resp = 1'b1; settle();
    total++; if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
      bad++; $display("FAIL sim_i_resp: got i=%b d=%b want 1 0", i_resp, d_resp);
    end
    step(); mem_resp = 1'b0; i_read = 1'b0;
    step();
  endtask

  task automatic test_both_ops();
    logic [LINE_W-1:0] wd;
    wd = rand_line();
    step();
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_2000; d_wdata = wd;
    step();
    d_addr = 32'h0000_3000; d_wdata = rand_line();
    settle();
    total++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin
      bad++; $display("FAIL both_strobe: got rd=%b wr=%b want 0 1", mem_read, mem_write);
    end
    step(); settle();
    total++; if (mem_addr !== 32'h0000_2000 || mem_wdata !== wd) begin
      bad++; $display("FAIL both_hold: got addr=%h wdata=%h want 00002000 %h", mem_addr, mem_wdata, wd);
    end
    step(); mem_resp = 1'b1; settle();
    total++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      bad++; $display("FAIL both_resp: got i=%b d=%b want 0 1", i_resp, d_resp);
    end
    step(); mem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
    step();
  endtask

  // Follows a lone D transaction, so round-robin prefers I and fixed priority prefers D.
  task automatic test_rr_pair();
    logic [ADDR_W-1:0] first_a, second_a;
    logic first_is_i;
`ifdef ARB_ROUND_ROBIN_EN
    first_is_i = 1'b1;
`else
    first_is_i = 1'b0;
`endif
    first_a  = first_is_i ? 32'h0000_1100 : 32'h0000_2200;
    second_a = first_is_i ? 32'h0000_2200 : 32'h0000_1100;
    step();
    i_read = 1'b1; i_addr = 32'h0000_1100;
    d_read = 1'b1; d_addr = 32'h0000_2200;
    step(); settle();
    total++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== first_a) begin
      bad++; $display("FAIL pair_first: got rd=%b wr=%b addr=%h want 1 0 %h", mem_read, mem_write, mem_addr, first_a);
    end
    step(); mem_resp = 1'b1; settle();
    total++; if (i_resp !== first_is_i || d_resp !== !first_is_i) begin
      bad++; $display("FAIL pair_first_resp: got i=%b d=%b want %b %b", i_resp, d_resp, first_is_i, !first_is_i);
    end
    step(); mem_resp = 1'b0;
    if (first_is_i) i_read = 1'b0; else d_read = 1'b0;
    step();
    step(); settle();
    total++; if (mem_read !== 1'b1 || mem_addr !== second_a) begin
      bad++; $display("FAIL pair_second: got rd=%b addr=%h want 1 %h", mem_read, mem_addr, second_a);
    end
    step(); mem_resp = 1'b1; settle();
    total++; if (i_resp !== !first_is_i || d_resp !== first_is_i) begin
      bad++; $display("FAIL pair_second_resp: got i=%b d=%b want %b %b", i_resp, d_resp, !first_is_i, first_is_i);
    end
    step(); mem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
    step(); settle();
    total++; if (arb_timeout !== 1'b0) begin bad++; $display("FAIL pair_timeout: got %b want 0", arb_timeout); end
  endtask

  task automatic test_stray_idle();
    step(); mem_resp = 1'b1; mem_rdata = rand_line(); settle();
    total++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      bad++; $display("FAIL stray_idle_resp: got i=%b d=%b want 0 0", i_resp, d_resp);
    end
    step(); mem_resp = 1'b0; settle();
    total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      bad++; $display("FAIL stray_idle_state: got rd=%b wr=%b want 0 0", mem_read, mem_write);
    end
  endtask

  task automatic test_random();
    int m_owner;                 // 0 none, 1 I-side, 2 D-side
    int m_cool;                  // cycles before the arbiter looks at requests again
    int m_lat, m_age, op;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;
    logic m_wr, m_pref_i, i_served, d_served, exp_rd, exp_wr, pick_d;
    do_reset();
    m_owner = 0; m_cool = 0; m_lat = 0; m_age = 0; m_wr = 1'b0; m_pref_i = 1'b0;
    m_addr = '0; m_wdata = '0; i_served = 1'b0; d_served = 1'b0;
    for (int c = 0; c < 600; c++) begin
      step();
      if (i_served) begin
        i_read = 1'b0; i_served = 1'b0;
      end else if (!i_read && c < 500 && $urandom_range(2) == 0) begin
        i_read = 1'b1; i_addr = $urandom;
      end else if (m_owner == 1) begin
        i_addr = $urandom;
      end
      if (d_served) begin
        d_read = 1'b0; d_write = 1'b0; d_served = 1'b0;
      end else if (!d_read && !d_write && c < 500 && $urandom_range(2) == 0) begin
        op = $urandom_range(2);
        d_read = (op != 1); d_write = (op != 0);
        d_addr = $urandom; d_wdata = rand_line();
      end else if (m_owner == 2) begin
        d_addr = $urandom; d_wdata = rand_line();
      end
      mem_rdata = rand_line();
      if (m_owner != 0) begin
        m_age++;
        mem_resp = (m_age == m_lat);
      end else begin
        mem_resp = ($urandom_range(3) == 0);
      end
      settle();
      exp_rd = (m_owner != 0) && !m_wr;
      exp_wr = (m_owner != 0) && m_wr;
      total++; if (mem_read !== exp_rd || mem_write !== exp_wr) begin
        bad++; $display("FAIL rnd_strobe c%0d: got rd=%b wr=%b want %b %b", c, mem_read, mem_write, exp_rd, exp_wr);
      end
      if (m_owner != 0) begin
        total++; if (mem_addr !== m_addr) begin
          bad++; $display("FAIL rnd_addr c%0d: got %h want %h", c, mem_addr, m_addr);
        end
        if (m_wr) begin
          total++; if (mem_wdata !== m_wdata) begin
            bad++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, mem_wdata, m_wdata);
          end
        end
      end
      total++; if (i_resp !== (m_owner == 1 && mem_resp) || d_resp !== (m_owner == 2 && mem_resp)) begin
        bad++; $display("FAIL rnd_resp c%0d: got i=%b d=%b want %b %b", c, i_resp, d_resp,
                        m_owner == 1 && mem_resp, m_owner == 2 && mem_resp);
      end
      if (m_owner != 0 && mem_resp) begin
        total++; if (i_rdata !== mem_rdata || d_rdata !== mem_rdata) begin
          bad++; $display("FAIL rnd_rdata c%0d: got i=%h d=%h want %h", c, i_rdata, d_rdata, mem_rdata);
        end
      end
      total++; if (arb_timeout !== 1'b0) begin
        bad++; $display("FAIL rnd_timeout c%0d: got %b want 0", c, arb_timeout);
      end
      // Advance the reference timeline to the next cycle.
      if (m_owner != 0) begin
        if (mem_resp) begin
          if (m_owner == 1) i_served = 1'b1; else d_served = 1'b1;
          m_pref_i = (m_owner == 2);
          m_owner = 0;
          m_cool = 1;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (i_read || d_read || d_write) begin
`ifdef ARB_ROUND_ROBIN_EN
        pick_d = (d_read || d_write) && !(i_read && m_pref_i);
`else
        pick_d = d_read || d_write;
`endif
        if (pick_d) begin
          m_owner = 2; m_wr = d_write; m_addr = d_addr; m_wdata = d_wdata;
        end else begin
          m_owner = 1; m_wr = 1'b0; m_addr = i_addr;
        end
        m_age = 0;
        m_lat = $urandom_range(1, 5);
      end
    end
    step();
    clear_inputs();
    repeat (3) step();
  endtask

  task automatic test_watchdog();
    step();
    i_read = 1'b1; i_addr = $urandom;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step(); settle();
      total++; if (arb_timeout !== (cyc >= TIMEOUT + 1)) begin
        bad++; $display("FAIL wd_flag c%0d: got %b want %b", cyc, arb_timeout, cyc >= TIMEOUT + 1);
      end
      total++; if (mem_read !== 1'b1) begin
        bad++; $display("FAIL wd_wait c%0d: got rd=%b want 1", cyc, mem_read);
      end
    end
    step(); mem_resp = 1'b1; settle();
    total++; if (i_resp !== 1'b1 || arb_timeout !== 1'b1) begin
      bad++; $display("FAIL wd_resp: got i=%b to=%b want 1 1", i_resp, arb_timeout);
    end
    for (int cyc = 14; cyc <= 16; cyc++) begin
      step(); mem_resp = 1'b0; i_read = 1'b0; settle();
      total++; if (arb_timeout !== 1'b1) begin
        bad++; $display("FAIL wd_sticky c%0d: got %b want 1", cyc, arb_timeout);
      end
    end
  endtask

  task automatic test_reset_mid();
    step();
    d_write = 1'b1; d_addr = 32'h0000_2000; d_wdata = rand_line();
    step(); step(); settle();
    total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL rmid_pre: got wr=%b want 1", mem_write); end
    rst = 1'b0; mem_resp = 1'b1;
    #1;
    total++; if (mem_write !== 1'b0 || mem_addr !== '0 || d_resp !== 1'b0 || arb_timeout !== 1'b0) begin
      bad++; $display("FAIL rmid_async: got wr=%b addr=%h d=%b to=%b want 0 0 0 0", mem_write, mem_addr, d_resp, arb_timeout);
    end
    d_write = 1'b0; mem_resp = 1'b0;
    step(); step();
    rst = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      mem_resp = (cyc % 2 == 0);
      settle();
      total++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
        bad++; $display("FAIL rmid_idle c%0d: got rd=%b wr=%b i=%b d=%b want 0 0 0 0", cyc, mem_read, mem_write, i_resp, d_resp);
      end
    end
    mem_resp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lone_read();
    test_simultaneous();
    test_both_ops();
    test_rr_pair();
    test_stray_idle();
    test_random();
    test_watchdog();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: got no finish want finish before 200000");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-client arbiter that shares the single main-memory (pmem) cache-line port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined RV32I core. One line transaction is granted at a time. The request is registered at grant, and the response is steered back to the owning client. It sits between the I-cache/D-cache and the burst/memory adapter, and carries a watchdog that flags a transaction that never completes.

## Interface
Parameters:
- ADDR_W, 32, address width (line-aligned; low bits passed through untouched)
- LINE_W, 256, cache-line width in bits
- TIMEOUT, 1024, cycles in a grant state without mem_resp before the timeout flag sets; 0 disables the watchdog

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_read  in  1  I-cache line-read request, level, held until i_resp
- i_addr  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  read line to I-cache
- i_resp  out  1  I-side completion, single-cycle
- d_read  in  1  D-cache line-read request, level
- d_write  in  1  D-cache line-write (writeback) request, level
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  writeback line
- d_rdata  out  LINE_W  read line to D-cache
- d_resp  out  1  D-side completion, single-cycle
- mem_read  out  1  memory read strobe, registered
- mem_write  out  1  memory write strobe, registered
- mem_addr  out  ADDR_W  registered transaction address
- mem_wdata  out  LINE_W  registered write line
- mem_rdata  in  LINE_W  memory read line
- mem_resp  in  1  memory completion, single-cycle
- arb_timeout  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D, DONE.
- IDLE:
  - With no request, stay in IDLE.
  - With requests, pick one by priority (see Configuration).
  - On grant, register the address, operation and wdata, then enter GRANT_I or GRANT_D.
  - I-side grants are always reads.
- D-side operation: if d_read and d_write are both high, d_write wins and the transaction is a write.
- GRANT_x:
  - mem_read/mem_write are held constant from the registered operation. mem_addr/mem_wdata are held constant.
  - On mem_resp, pulse the owning client's resp in the same cycle (combinational from mem_resp and state), then go to DONE.
  - The non-owning resp stays 0.
- Read data: i_rdata and d_rdata are both driven directly from mem_rdata. Only the resp qualifies the data.
- DONE:
  - One cycle with no memory strobes, which lets the served client drop its request.
  - Requests are ignored in DONE.
  - DONE always goes to IDLE.
- Client address/wdata changes after grant have no effect on the transaction in flight.
- Watchdog:
  - A counter clears on entry to GRANT_x and increments each cycle spent in GRANT_x without mem_resp.
  - When it reaches TIMEOUT, arb_timeout sets. It stays set until reset; the FSM keeps waiting.
  - The counter saturates and does not wrap.
  - Counter width is $clog2(TIMEOUT+1).
- mem_resp outside GRANT_x is ignored and produces no client resp.

## Timing
- Reset values: state IDLE, and all of the following are 0: mem_read, mem_write, mem_addr, mem_wdata, i_resp, d_resp, arb_timeout, watchdog counter, round-robin pointer.
- Reset is asynchronous, so any state returns to IDLE immediately. A transaction in flight is abandoned with no client resp.
- Request high in IDLE at edge N: strobe asserted in cycle N+1. Minimum grant latency is 1 cycle.
- mem_resp in cycle K: client resp in cycle K (zero latency), DONE in cycle K+1, IDLE in cycle K+2. The earliest next strobe is in cycle K+3.
- Back-to-back turnaround is 3 cycles from mem_resp to the next strobe.
- Strobes never overlap: at most one of mem_read/mem_write is high in any cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - A one-bit priority pointer selects the preferred client on simultaneous requests.
  - On each completed transaction (mem_resp in GRANT_x), the pointer points to the other client.
  - Reset value of the pointer is D-first.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: the D-side always wins a simultaneous request, and there is no pointer.
  - Under continuous D traffic the I-side can starve. This is the intended behaviour for the miss-path ordering.

## Test plan
- Lone I read: i_read=1, i_addr=0x0000_1040 at edge 0 -> mem_read=1 and mem_addr=0x0000_1040 in cycle 1. mem_resp in cycle 5 with mem_rdata=0xA5..A5 -> i_resp=1 in cycle 5, i_rdata=0xA5..A5, d_resp=0. mem_read=0 from cycle 6.
- Simultaneous requests: i_read and d_write (d_addr 0x2000, d_wdata=0x1234...) both at edge 0 -> D served first, with mem_write=1 and mem_wdata registered. After d_resp, the I read is granted 3 cycles after mem_resp. With ARB_ROUND_ROBIN_EN, a second simultaneous pair is served I-first.
- Both d_read and d_write high -> only mem_write asserts. After grant, d_addr changes to 0x3000 mid-transaction -> mem_addr stays 0x2000.
- Watchdog: TIMEOUT=8, grant a read, withhold mem_resp -> arb_timeout=1 exactly 8 cycles after the grant cycle. It stays 1 after a later mem_resp and completion.
- Reset mid-transaction: rst low during GRANT_D -> mem_write, mem_addr, d_resp and arb_timeout all 0 immediately. After release with no requests, the FSM stays idle and no resp is ever issued.
- Stray mem_resp in IDLE or DONE -> i_resp=d_resp=0 and the state is unchanged.
